// File: rtl/dmrs_hop_ctrl_pkg.sv
// dmrs_hop_ctrl_pkg: hop-mode encodings, modulus constants, FSM states and the PRS start-index helper.
package dmrs_hop_ctrl_pkg;
  localparam logic [1:0] HOP_NONE  = 2'd0;
  localparam logic [1:0] HOP_GROUP = 2'd1;
  localparam logic [1:0] HOP_SEQ   = 2'd2;
  localparam int MOD_N   = 30;
  localparam int PRS_LEN = 31;
  typedef enum logic [2:0] {IDLE, LOAD, CAPT, ACC, MOD_SS, MOD_GH, SUM, OUT} state_t;
  function automatic logic [4:0] mod31_x8(input logic [4:0] ns);
    logic [7:0] p;
    p = {ns, 3'b000};
    return 5'(p % 8'(PRS_LEN));
  endfunction
endpackage

// File: rtl/dmrs_hop_ctrl_mod30.sv
// mod30_iter: 11-bit operand mod 30 by six restoring subtractions of 960>>k, one per cycle.
module mod30_iter
  import dmrs_hop_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] operand,
  output logic        done,
  output logic [4:0]  result
);
  logic [10:0] rem, cur, sub, nxt;
  logic [2:0] k, kk;
  logic active;
  // The start cycle performs step 0 on the fresh operand; the last step's result is presented combinationally with done.
  always_comb begin
    kk = start ? 3'd0 : k;
    cur = start ? operand : rem;
    sub = 11'(MOD_N << 5) >> kk;
    nxt = (cur >= sub) ? cur - sub : cur;
    done = active && k == 3'd5;
    result = nxt[4:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      k <= '0;
      active <= 1'b0;
    end else if (start || active) begin
      rem <= nxt;
      k <= kk + 3'd1;
      active <= kk != 3'd5;
    end
  end
endmodule

// File: rtl/dmrs_hop_ctrl.sv
// dmrs_hop_ctrl: captures the PRS word for a slot and derives DMRS group number u and sequence number v.
module dmrs_hop_ctrl
  import dmrs_hop_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(NUM_SLOTS)-1:0] slot_num,
  input  logic [9:0]                   N_cell_ID,
  input  logic [4:0]                   delta_ss,
  input  logic [1:0]                   En_hopping,
  input  logic [30:0]                  pseudo_sequence,
  output logic [9:0]                   prs_N_cell_ID,
  output logic [1:0]                   prs_En_hopping,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4:0]                   u,
  output logic                         v
);
  state_t state, nxt;
  logic [4:0] ns_r, dss_r, idx, f_ss, f_gh;
  logic [9:0] id_r;
  logic [1:0] en_r;
  logic [30:0] seq_r;
  logic [7:0] acc;
  logic [2:0] cnt;
  logic [5:0] s;
  logic mod_start, mod_done;
  logic [10:0] mod_op;
  logic [4:0] mod_res;
  assign busy = state != IDLE;
  assign out_valid = state == OUT;
  assign prs_N_cell_ID = id_r;
  assign prs_En_hopping = en_r;
  assign s = 6'(f_gh) + 6'(f_ss);
  assign mod_start = (state == MOD_SS || state == MOD_GH) && cnt == 3'd0;
  assign mod_op = (state == MOD_SS) ? 11'(id_r) + 11'(dss_r) : 11'(acc);
  mod30_iter u_mod (
    .clk(clk),
    .rst_n(rst_n),
    .start(mod_start),
    .operand(mod_op),
    .done(mod_done),
    .result(mod_res)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = CAPT;
      CAPT:    nxt = ACC;
      ACC:     nxt = (cnt == 3'd7) ? MOD_SS : ACC;
      MOD_SS:  nxt = mod_done ? MOD_GH : MOD_SS;
      MOD_GH:  nxt = mod_done ? SUM : MOD_GH;
      SUM:     nxt = OUT;
      OUT:     nxt = out_ready ? IDLE : OUT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ns_r <= '0;
      dss_r <= '0;
      id_r <= '0;
      en_r <= '0;
      seq_r <= '0;
      acc <= '0;
      idx <= '0;
      cnt <= '0;
      f_ss <= '0;
      f_gh <= '0;
      u <= '0;
      v <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        ns_r <= 5'(slot_num);
        dss_r <= delta_ss;
        id_r <= N_cell_ID;
        en_r <= (En_hopping == 2'd3) ? HOP_NONE : En_hopping;
        acc <= '0;
        idx <= mod31_x8(5'(slot_num));
        cnt <= '0;
      end
      if (state == CAPT) seq_r <= pseudo_sequence;
      // Non-group modes still walk all 8 bits so latency stays mode-independent.
      if (state == ACC) begin
        acc <= acc + ((en_r == HOP_GROUP && seq_r[idx]) ? 8'd1 << cnt : 8'd0);
        idx <= (idx == 5'(PRS_LEN - 1)) ? 5'd0 : idx + 5'd1;
        cnt <= cnt + 3'd1;
      end
      if (state == MOD_SS || state == MOD_GH) cnt <= mod_done ? 3'd0 : cnt + 3'd1;
      if (state == MOD_SS && mod_done) f_ss <= mod_res;
      if (state == MOD_GH && mod_done) f_gh <= mod_res;
      if (state == SUM) begin
        u <= (s >= 6'(MOD_N)) ? 5'(s - 6'(MOD_N)) : 5'(s);
        v <= (en_r == HOP_SEQ) ? seq_r[ns_r] : 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dmrs_hop_ctrl.sv
// tb_dmrs_hop_ctrl: directed vector table, stall/reset sequences and random jobs against an arithmetic model.
module tb_dmrs_hop_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic [4:0] slot_num = '0, delta_ss = '0, u;
  logic [9:0] N_cell_ID = '0, prs_N_cell_ID;
  logic [1:0] En_hopping = '0, prs_En_hopping;
  logic [30:0] pseudo_sequence = '0;
  logic busy, out_valid, v;
  int npass = 0, ntot = 0;

  dmrs_hop_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .slot_num(slot_num), .N_cell_ID(N_cell_ID),
    .delta_ss(delta_ss), .En_hopping(En_hopping), .pseudo_sequence(pseudo_sequence),
    .prs_N_cell_ID(prs_N_cell_ID), .prs_En_hopping(prs_En_hopping), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .u(u), .v(v)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] en; logic [4:0] ns; logic [9:0] id; logic [4:0] dss; logic [30:0] seq;
    logic [4:0] eu; logic ev;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference straight from the definitions: c(k)=seq[k mod 31], plain modular arithmetic.
  function automatic void model(input logic [1:0] en, input int ns, input int id, input int dss,
                                input logic [30:0] seq, output int eu, output int ev);
    int acc = 0;
    if (en == 2'd1) for (int i = 0; i < 8; i++) acc += seq[(8 * ns + i) % 31] << i;
    eu = (acc % 30 + (id + dss) % 30) % 30;
    ev = (en == 2'd2) ? int'(seq[ns]) : 0;
  endfunction

  task automatic start_job(input logic [1:0] en, input logic [4:0] ns, input logic [9:0] id,
                           input logic [4:0] dss, input logic [30:0] seq);
    @(negedge clk);
    En_hopping = en; slot_num = ns; N_cell_ID = id; delta_ss = dss; pseudo_sequence = seq; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("prs_en_load", prs_En_hopping, (en == 2'd3) ? 2'd0 : en);
    chk("prs_id_load", prs_N_cell_ID, id);
  endtask

  // Counts edges after the start edge until out_valid; scrambles the PRS input once it should be latched.
  task automatic wait_valid(input logic [30:0] seq, output int lat);
    lat = 1;
    @(posedge clk); #1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) pseudo_sequence = ~seq;
    end
  endtask

  task automatic run_job(input string name, input logic [1:0] en, input logic [4:0] ns,
                         input logic [9:0] id, input logic [4:0] dss, input logic [30:0] seq,
                         input int eu, input int ev);
    int lat;
    start_job(en, ns, id, dss, seq);
    wait_valid(seq, lat);
    chk({name, "_lat"}, lat, 23);
    chk({name, "_u"}, u, eu);
    chk({name, "_v"}, v, ev);
    @(posedge clk); #1;
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin
    int eu, ev, lat;
    logic [4:0] hu;
    logic hv;
    tbl[0] = '{2'd1, 5'd0, 10'd0,    5'd0,  31'h7FFFFFFF, 5'd15, 1'b0};
    tbl[1] = '{2'd1, 5'd3, 10'd100,  5'd5,  31'h00000001, 5'd23, 1'b0};
    tbl[2] = '{2'd2, 5'd5, 10'd1023, 5'd29, 31'h00000020, 5'd2,  1'b1};
    tbl[3] = '{2'd1, 5'd7, 10'd29,   5'd0,  31'h7FFFFFFF, 5'd14, 1'b0};
    tbl[4] = '{2'd0, 5'd9, 10'd500,  5'd12, 31'h7FFFFFFF, 5'd2,  1'b0};
    tbl[5] = '{2'd3, 5'd7, 10'd29,   5'd0,  31'h7FFFFFFF, 5'd29, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_u", u, 0);
    chk("rst_prs_id", prs_N_cell_ID, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      run_job($sformatf("vec%0d", i), tbl[i].en, tbl[i].ns, tbl[i].id, tbl[i].dss, tbl[i].seq,
              tbl[i].eu, tbl[i].ev);
    // Held-off consumer: outputs frozen, new starts ignored.
    out_ready = 1'b0;
    start_job(2'd1, 5'd3, 10'd100, 5'd5, 31'h00000001);
    wait_valid(31'h00000001, lat);
    chk("stall_lat", lat, 23);
    hu = u; hv = v;
    chk("stall_u0", u, 23);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b1; slot_num = 5'(i); N_cell_ID = 10'(i * 77); En_hopping = 2'd2;
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_busy", busy, 1);
      chk("stall_u", u, hu);
      chk("stall_v", v, hv);
      chk("stall_prs_id", prs_N_cell_ID, 100);
    end
    @(negedge clk) start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_idle", busy, 0);
    chk("release_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("no_queued_start", busy, 0);
    // Asynchronous reset in the middle of accumulation.
    start_job(2'd1, 5'd7, 10'd29, 5'd0, 31'h7FFFFFFF);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_u", u, 0);
    chk("arst_v", v, 0);
    chk("arst_prs_id", prs_N_cell_ID, 0);
    chk("arst_prs_en", prs_En_hopping, 0);
    @(negedge clk) rst_n = 1'b1;
    run_job("post_rst", 2'd1, 5'd3, 10'd100, 5'd5, 31'h00000001, 23, 0);
    for (int i = 0; i < 30; i++) begin
      logic [1:0] en;
      logic [4:0] ns, dss;
      logic [9:0] id;
      logic [30:0] seq;
      en = 2'($urandom_range(0, 3));
      ns = 5'($urandom_range(0, 19));
      dss = 5'($urandom_range(0, 29));
      id = 10'($urandom_range(0, 1023));
      seq = 31'($urandom);
      model(en, int'(ns), int'(id), int'(dss), seq, eu, ev);
      run_job($sformatf("rnd%0d", i), en, ns, id, dss, seq, eu, ev);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
